// File: rtl/llki_pkg.sv
// -----------------------------------------------------------------------------
// llki_pkg
// Shared definitions for the LLKI mock TSS shims.
//   - llki_tss_state_t          : key-handling state machine encoding
//   - LLKI_KEY_WORD_WIDTH       : width of one LLKI discrete key word
//   - *_MOCK_TSS_KEY_WORDS      : per-core mock key constants, handed to
//                                 llki_mock_tss_gate as KEY_CONST by the
//                                 wrapper that instantiates each core
//   - llki_key_bits()           : total key width for a given word count
// -----------------------------------------------------------------------------
package llki_pkg;

    localparam int LLKI_KEY_WORD_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOADED = 2'd2,
        ST_CLEAR  = 2'd3
    } llki_tss_state_t;

    // Mock key constants, word 0 in the least significant 64 bits.
    localparam logic [2*LLKI_KEY_WORD_WIDTH-1:0] AES_MOCK_TSS_KEY_WORDS = {
        64'hA5A5_A5A5_A5A5_A5A5,
        64'h0F0F_0F0F_0F0F_0F0F
    };

    localparam logic [4*LLKI_KEY_WORD_WIDTH-1:0] SHA256_MOCK_TSS_KEY_WORDS = {
        64'h3C3C_3C3C_3C3C_3C3C,
        64'h5A5A_5A5A_5A5A_5A5A,
        64'hC3C3_C3C3_C3C3_C3C3,
        64'h9696_9696_9696_9696
    };

    localparam logic [1*LLKI_KEY_WORD_WIDTH-1:0] DES3_MOCK_TSS_KEY_WORDS =
        64'h6969_6969_6969_6969;

    function automatic int llki_key_bits(input int words);
        return words * LLKI_KEY_WORD_WIDTH;
    endfunction

endpackage

// File: rtl/llki_tss_key_fsm.sv
// -----------------------------------------------------------------------------
// llki_tss_key_fsm
// Key-handling half of the mock TSS gate: LLKI discrete handshake, word
// counter, key register, word-by-word zeroization and status flags.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_key_data          key word (word 0 first)
//   i_key_valid         key word valid
//   i_clear_key         clear request (pulse or level)
//   o_key_ready         a key word can be accepted this cycle
//   o_key_complete      full key present (level)
//   o_clear_key_ack     one-cycle pulse when zeroization is finished
//   o_key_error         sticky: word offered while the key was complete
//   o_key               flattened key register, word 0 in the low bits;
//                       only the datapath in the top level consumes it
// -----------------------------------------------------------------------------
module llki_tss_key_fsm
    import llki_pkg::*;
#(
    parameter int KEY_WORDS = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [LLKI_KEY_WORD_WIDTH-1:0]           i_key_data,
    input  logic                                     i_key_valid,
    input  logic                                     i_clear_key,
    output logic                                     o_key_ready,
    output logic                                     o_key_complete,
    output logic                                     o_clear_key_ack,
    output logic                                     o_key_error,
    output logic [LLKI_KEY_WORD_WIDTH*KEY_WORDS-1:0] o_key
);

    // The counter must also represent KEY_WORDS: in ST_CLEAR that value marks
    // the extra cycle after the last word was zeroed, where the ack is raised.
    localparam int             CNT_W    = $clog2(KEY_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] DONE_IDX = CNT_W'(KEY_WORDS);

    llki_tss_state_t                  r_state;
    llki_tss_state_t                  w_state_next;
    logic [CNT_W-1:0]                 r_cnt;
    logic [LLKI_KEY_WORD_WIDTH-1:0]   r_key [KEY_WORDS];
    logic                             r_run;
    logic                             r_ack;
    logic                             r_error;

    logic                             w_clear_req;
    logic                             w_accept;
    logic                             w_write;
    logic                             w_zero;

    // A clear already in progress ignores further clear requests.
    assign w_clear_req = i_clear_key & (r_state != ST_CLEAR);
    assign w_accept    = i_key_valid & o_key_ready;
    // Clear wins over a simultaneous accept: that word is dropped.
    assign w_write     = w_accept & ~w_clear_req;
    assign w_zero      = (r_state == ST_CLEAR) & (r_cnt != DONE_IDX);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_write) begin
                    w_state_next = (KEY_WORDS == 1) ? ST_LOADED : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_write && (r_cnt == LAST_IDX)) begin
                    w_state_next = ST_LOADED;
                end
            end
            ST_LOADED: begin
                w_state_next = ST_LOADED;
            end
            ST_CLEAR: begin
                if (r_cnt == DONE_IDX) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_clear_req) begin
            w_state_next = ST_CLEAR;
        end
    end

    // r_run holds ready low while reset is asserted even though the state
    // register already sits in ST_IDLE.
    always_comb begin
        o_key_ready    = 1'b0;
        o_key_complete = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: o_key_ready    = r_run;
            ST_LOADED:        o_key_complete = 1'b1;
            default: begin
                o_key_ready    = 1'b0;
                o_key_complete = 1'b0;
            end
        endcase
    end

    assign o_clear_key_ack = r_ack;
    assign o_key_error     = r_error;

    // ------------------------------------------------ counter and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_error <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_ack <= 1'b0;
            if (w_clear_req) begin
                r_cnt <= '0;
            end else if (w_write || w_zero) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == ST_CLEAR) begin
                // Every word is zero now: finish the clear.
                r_cnt   <= '0;
                r_ack   <= 1'b1;
                r_error <= 1'b0;
            end
            if ((r_state == ST_LOADED) && i_key_valid && !i_clear_key) begin
                r_error <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- key store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_key[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    if (w_write) begin
                        r_key[i] <= i_key_data;
                    end else if (w_zero) begin
                        r_key[i] <= '0;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key_out
            assign o_key[gi*LLKI_KEY_WORD_WIDTH +: LLKI_KEY_WORD_WIDTH] = r_key[gi];
        end
    endgenerate

endmodule

// File: rtl/llki_mock_tss_gate.sv
// -----------------------------------------------------------------------------
// llki_mock_tss_gate
// Mock TSS shim between the LLKI discrete interface and an unmodified crypto
// core. The low 64*KEY_WORDS bits of the core input are XORed with KEY_CONST
// and the loaded key; upper bits pass through. The core-side valid is blanked
// until a full key is present.
//
// Parameters:
//   KEY_WORDS   number of 64-bit key words (>= 1)
//   DATA_WIDTH  core input width (>= 64*KEY_WORDS)
//   KEY_CONST   per-core mock key constant (64*KEY_WORDS bits)
//   REG_OUT     1: registered output (1-cycle latency), 0: combinational
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   llkid_key_data/valid/ready       key word handshake
//   llkid_key_complete               full key loaded
//   llkid_clear_key / _ack           clear request / completion pulse
//   llkid_key_error                  sticky over-load error
//   core_in_data/valid               plaintext-side input
//   core_out_data/valid              masked data and gated qualifier to core
//   locked                           high whenever the key is not complete
// -----------------------------------------------------------------------------
module llki_mock_tss_gate
    import llki_pkg::*;
#(
    parameter int                                     KEY_WORDS  = 8,
    parameter int                                     DATA_WIDTH = 512,
    parameter logic [LLKI_KEY_WORD_WIDTH*KEY_WORDS-1:0] KEY_CONST  = '0,
    parameter bit                                     REG_OUT    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [LLKI_KEY_WORD_WIDTH-1:0] llkid_key_data,
    input  logic                           llkid_key_valid,
    output logic                           llkid_key_ready,
    output logic                           llkid_key_complete,
    input  logic                           llkid_clear_key,
    output logic                           llkid_clear_key_ack,
    output logic                           llkid_key_error,
    input  logic [DATA_WIDTH-1:0]          core_in_data,
    input  logic                           core_in_valid,
    output logic [DATA_WIDTH-1:0]          core_out_data,
    output logic                           core_out_valid,
    output logic                           locked
);

    localparam int KEY_BITS = llki_key_bits(KEY_WORDS);

    logic [KEY_BITS-1:0]   w_key;
    logic                  w_key_complete;
    logic [DATA_WIDTH-1:0] w_masked;
    logic                  w_valid;

    llki_tss_key_fsm #(
        .KEY_WORDS (KEY_WORDS)
    ) u_key_fsm (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_key_data      (llkid_key_data),
        .i_key_valid     (llkid_key_valid),
        .i_clear_key     (llkid_clear_key),
        .o_key_ready     (llkid_key_ready),
        .o_key_complete  (w_key_complete),
        .o_clear_key_ack (llkid_clear_key_ack),
        .o_key_error     (llkid_key_error),
        .o_key           (w_key)
    );

    assign llkid_key_complete = w_key_complete;
    assign locked             = ~w_key_complete;

    generate
        if (DATA_WIDTH > KEY_BITS) begin : g_passthru_hi
            assign w_masked = {core_in_data[DATA_WIDTH-1:KEY_BITS],
                               core_in_data[KEY_BITS-1:0] ^ KEY_CONST ^ w_key};
        end else begin : g_no_hi
            assign w_masked = core_in_data ^ KEY_CONST ^ w_key;
        end
    endgenerate

    assign w_valid = core_in_valid & w_key_complete;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_valid;

            // Data keeps flowing while locked; only the qualifier is gated.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_data  <= w_masked;
                    r_valid <= w_valid;
                end
            end

            // Re-gating with the current key_complete kills the beat that was
            // registered on the same edge a clear took effect.
            assign core_out_data  = r_data;
            assign core_out_valid = r_valid & w_key_complete;
        end else begin : g_comb_out
            assign core_out_data  = w_masked;
            assign core_out_valid = w_valid;
        end
    endgenerate

endmodule

// File: tb/tb_llki_mock_tss_gate.sv
module tb_llki_mock_tss_gate;

    localparam int          KW  = 2;
    localparam int          DW  = 192;
    localparam logic [127:0] TB_KEY_CONST = {64'hA5A5_A5A5_A5A5_A5A5, 64'h0F0F_0F0F_0F0F_0F0F};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   key_data;
    logic          key_valid;
    logic          key_ready;
    logic          key_complete;
    logic          clear_key;
    logic          clear_ack;
    logic          key_error;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          locked;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    llki_mock_tss_gate #(
        .KEY_WORDS  (KW),
        .DATA_WIDTH (DW),
        .KEY_CONST  (TB_KEY_CONST),
        .REG_OUT    (1'b1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .llkid_key_data      (key_data),
        .llkid_key_valid     (key_valid),
        .llkid_key_ready     (key_ready),
        .llkid_key_complete  (key_complete),
        .llkid_clear_key     (clear_key),
        .llkid_clear_key_ack (clear_ack),
        .llkid_key_error     (key_error),
        .core_in_data        (in_data),
        .core_in_valid       (in_valid),
        .core_out_data       (out_data),
        .core_out_valid      (out_valid),
        .locked              (locked)
    );

    // ------------------------------------------------ behavioural model
    // Key as plain words, number of words loaded, and a clear in progress
    // counted in edges since the clear was taken.
    logic [63:0]   m_key [KW];
    int            m_n;
    bit            m_clr;
    int            m_clr_cyc;
    bit            m_err;
    bit            m_ack;
    bit            m_alive;
    logic [DW-1:0] m_out;
    bit            m_out_v;

    function automatic bit m_complete();
        return !m_clr && (m_n == KW);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < KW; i++) m_key[i] = '0;
        m_n = 0; m_clr = 0; m_clr_cyc = 0; m_err = 0; m_ack = 0;
        m_alive = 0; m_out = '0; m_out_v = 0;
    endtask

    task automatic model_edge();
        bit           was_complete;
        bit           beat;
        logic [127:0] mask;
        was_complete = m_complete();
        mask  = TB_KEY_CONST ^ {m_key[1], m_key[0]};
        m_out = {in_data[191:128], in_data[127:0] ^ mask};
        beat  = in_valid && was_complete;
        m_ack = 0;
        if (m_clr) begin
            m_clr_cyc++;
            if (m_clr_cyc <= KW) begin
                m_key[m_clr_cyc-1] = '0;
            end else begin
                m_clr = 0; m_ack = 1; m_err = 0; m_n = 0;
            end
        end else if (clear_key) begin
            m_clr = 1; m_clr_cyc = 0;
        end else if (key_valid && m_alive && m_n < KW) begin
            m_key[m_n] = key_data;
            m_n++;
        end else if (key_valid && m_n == KW) begin
            m_err = 1;
        end
        m_alive = 1;
        m_out_v = beat && m_complete();
    endtask

    // -------------------------------------------------------- checking
    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("ready",    DW'(key_ready),    DW'(m_alive && !m_clr && m_n < KW));
        check_eq("complete", DW'(key_complete), DW'(m_complete()));
        check_eq("locked",   DW'(locked),       DW'(!m_complete()));
        check_eq("ack",      DW'(clear_ack),    DW'(m_ack));
        check_eq("error",    DW'(key_error),    DW'(m_err));
        check_eq("out_v",    DW'(out_valid),    DW'(m_out_v));
        check_eq("out_data", out_data,          m_out);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_all();
    endtask

    function automatic logic [DW-1:0] rand192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic do_clear_to_idle();
        clear_key = 1'b1;
        tick();
        clear_key = 1'b0;
        repeat (KW + 1) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acks;
        logic [DW-1:0] probe;

        rst_n = 1'b0; key_data = '0; key_valid = 1'b0; clear_key = 1'b0;
        in_data = '0; in_valid = 1'b0;
        model_reset();

        // Reset and first cycle after release
        $display("phase: reset");
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = 192'h1;
        tick();
        check_eq("ready_post_rst", DW'(key_ready), DW'(1'b1));
        check_eq("valid_locked",   DW'(out_valid), DW'(1'b0));

        // Back-to-back key load
        $display("phase: load 1111.. / 2222..");
        key_valid = 1'b1; key_data = 64'h1111_1111_1111_1111;
        tick();
        key_data = 64'h2222_2222_2222_2222;
        tick();
        check_eq("complete_after_load", DW'(key_complete), DW'(1'b1));
        key_valid = 1'b0;
        probe = {64'hDEAD_BEEF_CAFE_F00D, 128'h0};
        in_data = probe;
        tick();
        check_eq("mask_const", out_data,
                 {64'hDEAD_BEEF_CAFE_F00D, 64'h8787_8787_8787_8787, 64'h1E1E_1E1E_1E1E_1E1E});
        check_eq("valid_loaded", DW'(out_valid), DW'(1'b1));

        // Extra word after complete
        $display("phase: over-load error");
        key_valid = 1'b1; key_data = rand64();
        tick();
        key_valid = 1'b0;
        repeat (2) tick();
        check_eq("error_sticky", DW'(key_error), DW'(1'b1));
        check_eq("mask_unchanged", out_data,
                 {64'hDEAD_BEEF_CAFE_F00D, 64'h8787_8787_8787_8787, 64'h1E1E_1E1E_1E1E_1E1E});

        // Clear: ack latency
        $display("phase: clear");
        clear_key = 1'b1;
        tick();
        clear_key = 1'b0;
        check_eq("valid_first_locked", DW'(out_valid), DW'(1'b0));
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (clear_ack) lat = i;
        end
        check_eq("ack_latency", DW'(lat), DW'(3));
        check_eq("error_cleared", DW'(key_error), DW'(1'b0));
        in_data = probe;
        tick();
        check_eq("zeroized_mask", out_data, {64'hDEAD_BEEF_CAFE_F00D, TB_KEY_CONST});

        // Clear coinciding with second word
        $display("phase: partial load clear");
        key_valid = 1'b1; key_data = rand64();
        tick();
        key_data = rand64(); clear_key = 1'b1;
        tick();
        key_valid = 1'b0; clear_key = 1'b0;
        repeat (KW + 2) tick();
        key_valid = 1'b1; key_data = rand64();
        tick();
        key_data = rand64();
        tick();
        key_valid = 1'b0;
        repeat (3) begin
            in_data = rand192(); in_valid = 1'b1;
            tick();
        end

        // Random traffic against the model
        $display("phase: random");
        repeat (400) begin
            key_valid = ($urandom_range(0, 9) < 3);
            key_data  = rand64();
            clear_key = ($urandom_range(0, 99) < 4);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = rand192();
            tick();
        end
        key_valid = 1'b0; clear_key = 1'b0;

        // Asynchronous reset in the middle of a load
        $display("phase: reset mid-load");
        do_clear_to_idle();
        key_valid = 1'b1; key_data = rand64();
        tick();
        key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        check_eq("rst_load_ready", DW'(key_ready), DW'(1'b0));
        tick();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) tick();

        // Asynchronous reset in the middle of a clear
        $display("phase: reset mid-clear");
        key_valid = 1'b1; key_data = rand64();
        repeat (KW) tick();
        key_valid = 1'b0;
        clear_key = 1'b1;
        tick();
        clear_key = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        check_eq("rst_clear_data", out_data, DW'(0));
        tick();
        @(negedge clk) rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            tick();
            if (clear_ack) acks++;
        end
        check_eq("no_ack_after_rst", DW'(acks), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
